// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller for a 5-stage MIPS pipeline with branches
// resolved in ID. It detects three kinds of hazard:
//   - load-use     : the EX instruction is a load whose result ID needs
//   - branch       : a branch in ID needs a value still in EX, or still being
//                    loaded in MEM
//   - mult/div     : ID touches HI/LO while the mult/div unit is busy
// All hazards get the same response: hold PC and IF/ID, and put a bubble into
// ID/EX.
//
// Optional build macro: HAZARD_STATS_EN adds three 32-bit cycle counters
// (stallCnt, lwStallCnt, mdStallCnt).
//
// Parameters:
//   MD_LATENCY  cycles HI/LO stays busy after a mult/div leaves EX (1..63)
//   CNT_W       busy counter width, 2**CNT_W > MD_LATENCY
//
// Ports:
//   clk, rst              pipeline clock; asynchronous active-low reset
//   rsD, rtD              source register fields of the ID instruction
//   useRsD, useRtD        ID instruction actually reads rs / rt
//   branchD               ID instruction is a branch compared in ID
//   hiloUseD              ID instruction uses the HI/LO unit
//   regWriteE, memToRegE  EX instruction writes the register file / is a load
//   writeRegE             EX destination register
//   mdStartE              EX instruction is mult/multu/div/divu
//   memToRegM, writeRegM  MEM instruction is a load / its destination
//   stallF, stallD        hold PC / hold IF/ID
//   clearE                clear input of ID/EX (inserts a bubble)
//   mdBusy                HI/LO unit busy
//   stallCnt, lwStallCnt, mdStallCnt   (HAZARD_STATS_EN only) cycle counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic        useRsD,
   input  logic        useRtD,
   input  logic        branchD,
   input  logic        hiloUseD,
   input  logic        regWriteE,
   input  logic        memToRegE,
   input  logic [4:0]  writeRegE,
   input  logic        mdStartE,
   input  logic        memToRegM,
   input  logic [4:0]  writeRegM,
   output logic        stallF,
   output logic        stallD,
   output logic        clearE,
   output logic        mdBusy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stallCnt,
   output logic [31:0] lwStallCnt,
   output logic [31:0] mdStallCnt
`endif
);

   logic             match_e;
   logic             match_m;
   logic             lw_stall;
   logic             br_stall;
   logic             md_stall;
   logic             stall;
   logic [CNT_W-1:0] md_cnt;

   // $zero is hard-wired, so writing it never creates a dependency.
   assign match_e = (writeRegE != 5'd0) &&
                    ((useRsD && (rsD == writeRegE)) || (useRtD && (rtD == writeRegE)));
   assign match_m = (writeRegM != 5'd0) &&
                    ((useRsD && (rsD == writeRegM)) || (useRtD && (rtD == writeRegM)));

   assign lw_stall = memToRegE && regWriteE && match_e;
   // Any EX result is too late for a branch compared in ID. A MEM result can
   // be forwarded unless it is a load that is still reading memory.
   assign br_stall = branchD && ((regWriteE && match_e) || (memToRegM && match_m));
   // mdStartE is included so that the instruction right behind a mult/div
   // waits before mdBusy has risen.
   assign md_stall = hiloUseD && (mdBusy || mdStartE);

   assign stall  = lw_stall | br_stall | md_stall;
   assign stallF = stall;
   assign stallD = stall;
   assign clearE = stall;

   // HI/LO busy timer. A new mult/div reloads the count even mid-window,
   // because the newest operation sets when HI/LO is ready again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         md_cnt <= '0;
      end else if (mdStartE) begin
         md_cnt <= CNT_W'(MD_LATENCY);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - CNT_W'(1);
      end
   end

   assign mdBusy = (md_cnt != '0);

`ifdef HAZARD_STATS_EN
   // Free-running statistics; they wrap at 2**32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt   <= '0;
         lwStallCnt <= '0;
         mdStallCnt <= '0;
      end else begin
         if (stall)    stallCnt   <= stallCnt + 32'd1;
         if (lw_stall) lwStallCnt <= lwStallCnt + 32'd1;
         if (md_stall) mdStallCnt <= mdStallCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl with MD_LATENCY=4. Inputs change on the
// falling clock edge and outputs are sampled 1 ns later, well away from the
// rising edge. Define HAZARD_STATS_EN to also cover the statistics counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rsD, rtD, writeRegE, writeRegM;
   logic        useRsD, useRtD, branchD, hiloUseD;
   logic        regWriteE, memToRegE, mdStartE, memToRegM;
   logic        stallF, stallD, clearE, mdBusy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stallCnt, lwStallCnt, mdStallCnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .rsD       (rsD),
      .rtD       (rtD),
      .useRsD    (useRsD),
      .useRtD    (useRtD),
      .branchD   (branchD),
      .hiloUseD  (hiloUseD),
      .regWriteE (regWriteE),
      .memToRegE (memToRegE),
      .writeRegE (writeRegE),
      .mdStartE  (mdStartE),
      .memToRegM (memToRegM),
      .writeRegM (writeRegM),
      .stallF    (stallF),
      .stallD    (stallD),
      .clearE    (clearE),
      .mdBusy    (mdBusy)
`ifdef HAZARD_STATS_EN
      ,
      .stallCnt  (stallCnt),
      .lwStallCnt(lwStallCnt),
      .mdStallCnt(mdStallCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_stall(input string tag, input logic exp);
      check({tag, "_stallF"}, {31'd0, stallF}, {31'd0, exp});
      check({tag, "_stallD"}, {31'd0, stallD}, {31'd0, exp});
      check({tag, "_clearE"}, {31'd0, clearE}, {31'd0, exp});
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; writeRegE = 0; writeRegM = 0;
      useRsD = 0; useRtD = 0; branchD = 0; hiloUseD = 0;
      regWriteE = 0; memToRegE = 0; mdStartE = 0; memToRegM = 0;
   endtask

   // Advance to the next falling edge (inputs may then be changed).
   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #3;
      check_stall("reset", 1'b0);
      check("reset_mdBusy", {31'd0, mdBusy}, 32'd0);
`ifdef HAZARD_STATS_EN
      check("reset_stallCnt", stallCnt, 32'd0);
`endif
      next_cyc();
      rst = 1'b1;

      // ---------------- load-use ----------------
      next_cyc();
      memToRegE = 1; regWriteE = 1; writeRegE = 8; rsD = 8; useRsD = 1;
      #1 check_stall("lw_rs", 1'b1);
      writeRegE = 0; rsD = 0;
      #1 check_stall("lw_r0", 1'b0);
      writeRegE = 8; rsD = 8; regWriteE = 0;
      #1 check_stall("lw_nowrite", 1'b0);
      regWriteE = 1; useRsD = 0;
      #1 check_stall("lw_rs_unused", 1'b0);
      useRtD = 1; rtD = 8; rsD = 3;
      #1 check_stall("lw_rt", 1'b1);
      memToRegE = 0;
      #1 check_stall("alu_in_ex_no_branch", 1'b0);

      // ---------------- branch ----------------
      next_cyc();
      clear_inputs();
      branchD = 1; rtD = 9; useRtD = 1; memToRegM = 1; writeRegM = 9;
      #1 check_stall("br_mem_load", 1'b1);
      writeRegM = 10;
      #1 check_stall("br_mem_other", 1'b0);
      writeRegM = 9; memToRegM = 0;
      #1 check_stall("br_mem_alu", 1'b0);
      regWriteE = 1; writeRegE = 9;
      #1 check_stall("br_ex_alu", 1'b1);
      branchD = 0;
      #1 check_stall("nobr_ex_alu", 1'b0);

      // ---------------- mult/div busy window ----------------
      next_cyc();
      clear_inputs();
      mdStartE = 1; hiloUseD = 1;
      #1 check_stall("md_c0", 1'b1);
      check("md_c0_busy", {31'd0, mdBusy}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         next_cyc();
         mdStartE = 0;
         #1;
         check($sformatf("md_c%0d", k), {31'd0, stallF}, (k <= 4) ? 32'd1 : 32'd0);
         check($sformatf("md_c%0d_busy", k), {31'd0, mdBusy}, (k <= 4) ? 32'd1 : 32'd0);
      end

      // busy but ID does not touch HI/LO: no stall
      next_cyc();
      clear_inputs();
      mdStartE = 1;
      next_cyc();
      mdStartE = 0;
      #1 check_stall("md_busy_nohilo", 1'b0);
      check("md_busy_nohilo_busy", {31'd0, mdBusy}, 32'd1);
      repeat (5) next_cyc();

      // ---------------- reload ----------------
      clear_inputs();
      mdStartE = 1;
      for (int k = 1; k <= 7; k++) begin
         next_cyc();
         mdStartE = (k == 2);
         #1 check($sformatf("reload_c%0d_busy", k), {31'd0, mdBusy}, (k <= 6) ? 32'd1 : 32'd0);
      end

      // ---------------- reset mid-count ----------------
      next_cyc();
      clear_inputs();
      mdStartE = 1;
      next_cyc();
      mdStartE = 0;
      next_cyc();
      #1 check("rstmid_c2_busy", {31'd0, mdBusy}, 32'd1);
      #1 rst = 1'b0;
      #1 check("rstmid_async_busy", {31'd0, mdBusy}, 32'd0);
      next_cyc();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         #1 check($sformatf("after_rst_c%0d_busy", k), {31'd0, mdBusy}, 32'd0);
      end
      mdStartE = 1;
      next_cyc();
      mdStartE = 0;
      #1 check("restart_busy", {31'd0, mdBusy}, 32'd1);
      repeat (5) next_cyc();

`ifdef HAZARD_STATS_EN
      // ---------------- statistics ----------------
      clear_inputs();
      rst = 1'b0;
      #1 check("stats_rst_stallCnt", stallCnt, 32'd0);
      next_cyc();
      rst = 1'b1;
      memToRegE = 1; regWriteE = 1; writeRegE = 5; rsD = 5; useRsD = 1;
      repeat (3) next_cyc();
      clear_inputs();
      mdStartE = 1;
      next_cyc();
      mdStartE = 0; hiloUseD = 1;
      repeat (4) next_cyc();
      hiloUseD = 0;
      #1;
      check("stats_stallCnt",   stallCnt,   32'd7);
      check("stats_lwStallCnt", lwStallCnt, 32'd3);
      check("stats_mdStallCnt", mdStallCnt, 32'd4);
      rst = 1'b0;
      #1;
      check("stats_clr_stallCnt",   stallCnt,   32'd0);
      check("stats_clr_lwStallCnt", lwStallCnt, 32'd0);
      check("stats_clr_mdStallCnt", mdStallCnt, 32'd0);
      next_cyc();
      rst = 1'b1;
`endif

      next_cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
